serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial WIDTH-bit adder built around one full_adder cell. Accepts A, B, Cin
//   over a valid/ready input handshake. Feeds the cell one operand bit pair per cycle,
//   LSB first, and carries through a register. Presents Sum/Cout over a valid/ready
//   output handshake. Sits directly upstream of, and drives, the single full_adder instance.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..64
// PORTS
//   Clk        in   1      clock; all state updates on the rising edge
//   Rst_N      in   1      asynchronous, active-low reset
//   In_Valid   in   1      operands A/B/Cin valid this cycle
//   In_Ready   out  1      block can accept operands this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   Cin        in   1      carry-in to bit 0
//   Out_Valid  out  1      Sum/Cout hold a completed result
//   Out_Ready  in   1      downstream takes the result this cycle
//   Sum        out  WIDTH  A+B+Cin, modulo 2^WIDTH
//   Cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   Reset (Rst_N low, async): state=IDLE; shift regs, carry reg and counter=0.
//     Out_Valid=0, Sum=0, Cout=0. In_Ready forced 0 while Rst_N is low.
//   FSM states IDLE, RUN, DONE. In_Ready = (state==IDLE) & Rst_N. Out_Valid = (state==DONE).
//   IDLE: In_Valid=1 (transfer) -> load a_sh=A, b_sh=B, carry=Cin, cnt=0; go to RUN.
//     In_Valid=0 -> stay.
//   RUN: the cell sees a_sh[0], b_sh[0], carry. Each edge:
//     sum_sh <= {cell Sum, sum_sh[WIDTH-1:1]}; carry <= cell Cout;
//     a_sh, b_sh shift right by 1; cnt++.
//     cnt==WIDTH-1 -> go to DONE. Exactly WIDTH cycles are spent in RUN.
//   DONE: Sum=sum_sh, Cout=carry. Out_Ready=1 -> IDLE. Out_Ready=0 -> hold.
//   Latency: input transfer at edge E0 -> Out_Valid high from edge E0+WIDTH.
//   Min op spacing: WIDTH+2 cycles (accept, WIDTH run cycles, DONE with Out_Ready=1).
//   Sum/Cout are registered and hold the last result through IDLE/RUN until the next
//     DONE. They are only meaningful while Out_Valid=1.
//   Operand inputs are ignored outside IDLE. In_Valid during RUN/DONE is not a transfer;
//     the upstream must hold it.
//   Out_Ready while not in DONE has no effect. No input is accepted in the cycle DONE exits.
//   Counter width $clog2(WIDTH); no wrap beyond WIDTH-1. Carry never leaks between ops:
//     it is reloaded from Cin on every accept.
//   Reset mid-RUN or mid-DONE aborts the op. No Out_Valid is produced for it, and the
//     op is not replayed.
// STRUCTURE
//   Shared package serial_adder_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE}
//     sadd_state_t.
//   Sub-module: exactly one full_adder instance (u_fa); all else inline
//     (FSM, shift regs, counter).
// TESTING
//   1. WIDTH=8: A=0x5A, B=0x33, Cin=0 -> Sum=0x8D, Cout=0. Out_Valid rises exactly
//      8 edges after the accept edge.
//   2. A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1.
//   3. Hold Out_Ready=0 for 5 cycles in DONE -> Out_Valid, Sum, Cout stable; In_Ready=0;
//      new In_Valid not taken.
//   4. Drop Rst_N after 3 RUN cycles of 0xFF+0xFF -> Out_Valid=0, Sum=0. After release,
//      0x10+0x20+0 -> 0x30, Cout=0.
//   5. In_Valid and Out_Ready tied high, 1000 random ops -> each result matches A+B+Cin;
//      accepts spaced exactly WIDTH+2 cycles.
//   6. WIDTH=2: A=3, B=3, Cin=1 -> Sum=3, Cout=1, Out_Valid 2 edges after accept.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell driven one bit pair per cycle by serial_adder.
module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full adder cell, carry held in a register,
// valid/ready handshakes on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    sadd_state_t      state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CntW-1:0]  cnt_q;
    logic             fa_sum;
    logic             fa_cout;

    serial_adder_full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= fa_cout;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    if (cnt_q == CntLast) begin
                        // Capture the final word directly so the result holds until the next op.
                        sum_q   <= {fa_sum, sum_sh_q[WIDTH-1:1]};
                        cout_q  <= fa_cout;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) & rst_n;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, handshake corner cases, random stream.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct packed {
        logic         co;
        logic [W-1:0] s;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    logic         w2_in_valid = 1'b0;
    logic         w2_in_ready;
    logic [1:0]   w2_a = '0;
    logic [1:0]   w2_b = '0;
    logic         w2_cin = 1'b0;
    logic         w2_out_valid;
    logic [1:0]   w2_sum;
    logic         w2_cout;

    int unsigned  cyc = 0;
    int           errors = 0;
    int           checks = 0;
    res_t         sb[$];
    vec_t         vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_adder #(.WIDTH(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w2_in_valid),
        .in_ready  (w2_in_ready),
        .a         (w2_a),
        .b         (w2_b),
        .cin       (w2_cin),
        .out_valid (w2_out_valid),
        .out_ready (1'b1),
        .sum       (w2_sum),
        .cout      (w2_cout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_in_ready();
        for (int k = 0; k < 50; k++) begin
            if (in_ready) return;
            @(negedge clk);
        end
        check("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_out_valid(output int unsigned at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                at_cyc = cyc;
                return;
            end
        end
        check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic pop_compare(input string name);
        res_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_sum"}, 64'(sum), 64'(e.s));
        check({name, "_cout"}, 64'(cout), 64'(e.co));
    endtask

    // One directed op; 'hold' keeps out_ready low in DONE while offering a competing input.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input res_t exp, input int hold, input string name);
        int unsigned acc;
        int unsigned done_at;
        bit ok;
        logic [W-1:0] s0;
        logic c0;
        wait_in_ready();
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        acc = cyc;
        in_valid = 1'b0;
        wait_out_valid(done_at, ok);
        if (!ok) return;
        check({name, "_latency"}, 64'(done_at - acc), 64'(W));
        s0 = sum;
        c0 = cout;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = ~va;
            b = 8'h11;
            @(negedge clk);
            check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({name, "_hold_sum"}, 64'(sum), 64'(s0));
            check({name, "_hold_cout"}, 64'(cout), 64'(c0));
            check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        pop_compare(name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // Input held high across the DONE exit edge must not have been taken.
        check({name, "_exit_valid"}, 64'(out_valid), 64'd0);
        check({name, "_exit_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int unsigned prev_acc;
        int unsigned acc;
        int unsigned done_at;
        bit ok;
        bit seen;
        logic [W:0] full;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_w2_in_ready", 64'(w2_in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, '{co: vecs[i].co, s: vecs[i].s}, 0,
                  $sformatf("vec%0d", i));
        end

        // Back-pressure in DONE
        do_op(8'h5A, 8'h33, 1'b0, '{co: 1'b0, s: 8'h8D}, 5, "hold");

        // Abort mid-RUN: no result may appear for it
        wait_in_ready();
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_replay", 64'(seen), 64'd0);
        do_op(8'h10, 8'h20, 1'b0, '{co: 1'b0, s: 8'h30}, 0, "after_abort");

        // Streaming with both handshakes tied high
        out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            wait_in_ready();
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            in_valid = 1'b1;
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            sb.push_back('{co: full[W], s: full[W-1:0]});
            @(negedge clk);
            acc = cyc;
            if (i > 0) check("rand_spacing", 64'(acc - prev_acc), 64'(W + 2));
            prev_acc = acc;
            wait_out_valid(done_at, ok);
            if (!ok) break;
            pop_compare("rand");
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // WIDTH=2 instance
        for (int k = 0; k < 50 && !w2_in_ready; k++) @(negedge clk);
        check("w2_in_ready", 64'(w2_in_ready), 64'd1);
        w2_a = 2'd3;
        w2_b = 2'd3;
        w2_cin = 1'b1;
        w2_in_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        w2_in_valid = 1'b0;
        done_at = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (w2_out_valid) begin
                done_at = cyc;
                break;
            end
        end
        check("w2_out_valid", 64'(w2_out_valid), 64'd1);
        check("w2_latency", 64'(done_at - acc), 64'd2);
        check("w2_sum", 64'(w2_sum), 64'd3);
        check("w2_cout", 64'(w2_cout), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
